// File: rtl/tone_generator.sv
// Square-wave tone synthesiser: toggles tone_o every div_q cycles, with glitch-free divider reloads.
// Optional TONE_GAP_EN macro adds a silent GAP state of GAP_CYCLES cycles after each note strobe.
module tone_generator #(
  parameter int BW         = 16,
  parameter int GAP_CYCLES = 4096
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          enable_i,
  input  logic [BW-1:0] divider_value_i,
  input  logic          note_strobe_i,
  output logic          tone_o,
  output logic          active_o,
  output logic          half_period_o
);

`ifdef TONE_GAP_EN
  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  if (GAP_CYCLES < 1) begin : g_cfg_check
    $error("tone_generator: GAP_CYCLES must be at least 1");
  end

  state_t        state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] div_q, div_d;
  logic          tone_q, tone_d;
  logic          active_q, active_d;
  logic          half_q, half_d;
  logic          div_nonzero;
  logic          boundary;
`ifdef TONE_GAP_EN
  logic [GW-1:0] gap_q, gap_d;
  logic          gap_done;
`endif

  assign div_nonzero = (divider_value_i != '0);
  assign boundary    = (cnt_q == div_q - BW'(1));
`ifdef TONE_GAP_EN
  assign gap_done    = (gap_q == GW'(GAP_CYCLES - 1));
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      tone_q   <= 1'b0;
      active_q <= 1'b0;
      half_q   <= 1'b0;
`ifdef TONE_GAP_EN
      gap_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      tone_q   <= tone_d;
      active_q <= active_d;
      half_q   <= half_d;
`ifdef TONE_GAP_EN
      gap_q    <= gap_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    tone_d   = tone_q;
    active_d = active_q;
    half_d   = 1'b0;
`ifdef TONE_GAP_EN
    gap_d    = gap_q;
`endif

    if (!enable_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      tone_d   = 1'b0;
      active_d = 1'b0;
    end else if (note_strobe_i) begin
`ifdef TONE_GAP_EN
      state_d  = GAP;
      gap_d    = '0;
      cnt_d    = '0;
      tone_d   = 1'b0;
      active_d = 1'b0;
`else
      // Phase restart: the new note always begins with a full low half-period.
      cnt_d    = '0;
      tone_d   = 1'b0;
      div_d    = divider_value_i;
      state_d  = div_nonzero ? RUN : IDLE;
      active_d = div_nonzero;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tone_d = 1'b0;
          if (div_nonzero) begin
            div_d    = divider_value_i;
            cnt_d    = '0;
            state_d  = RUN;
            active_d = 1'b1;
          end
        end
        RUN: begin
          if (boundary) begin
            // Divider is only sampled here, so mid-phase changes never shorten a phase.
            cnt_d  = '0;
            div_d  = divider_value_i;
            half_d = 1'b1;
            if (div_nonzero) begin
              tone_d = ~tone_q;
            end else begin
              tone_d   = 1'b0;
              state_d  = IDLE;
              active_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + BW'(1);
          end
        end
`ifdef TONE_GAP_EN
        GAP: begin
          tone_d = 1'b0;
          if (gap_done) begin
            if (div_nonzero) begin
              div_d    = divider_value_i;
              cnt_d    = '0;
              state_d  = RUN;
              active_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
`endif
        default: begin
          state_d  = IDLE;
          tone_d   = 1'b0;
          active_d = 1'b0;
        end
      endcase
    end
  end

  assign tone_o        = tone_q;
  assign active_o      = active_q;
  assign half_period_o = half_q;

endmodule
